draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/drawing_pkg.sv | 37 +++
 rtl/raster_counter.sv | 65 ++++++
 rtl/draw_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_draw_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/drawing_pkg.sv
// Shared drawing definitions: control-state codes, screen geometry defaults,
// colour constants, coordinate widths and the sequencer FSM encoding.
package drawing_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int ST_W  = 3;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [COL_W-1:0] BG_COLOUR_DEF  = 3'b111;
  localparam logic [COL_W-1:0] CUR_COLOUR_DEF = 3'b000;

  // Drawing control-path state codes (code 7 is unused and inactive).
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_MOVE  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_CLEAN = 3'd3;
  localparam logic [ST_W-1:0] ST_DRAW  = 3'd4;
  localparam logic [ST_W-1:0] ST_ERASE = 3'd5;
  localparam logic [ST_W-1:0] ST_CLEAR = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  // True for the control states that ask the sequencer to plot something.
  function automatic logic is_active(input logic [ST_W-1:0] s);
    return (s == ST_MOVE) || (s == ST_CLEAN) || (s == ST_DRAW) ||
           (s == ST_ERASE) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// 2D raster counter: x counts fastest from 0 to x_max, then y steps, up to
// y_max. Used for both brush squares and full-screen sweeps.
module raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [XW-1:0] x_max,
  input  logic [YW-1:0] y_max,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last,
  output logic          almost_last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Next position: clear wins, otherwise step in raster order when enabled.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == x_max) begin
        x_d = '0;
        y_d = (y_q == y_max) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // last: sitting on the final position. almost_last: one step before it
  // (never set for a 1x1 sweep, which has no such position).
  always_comb begin
    last        = (x_q == x_max) && (y_q == y_max);
    almost_last = 1'b0;
    if (x_max != '0) begin
      almost_last = (x_q == x_max - XW'(1)) && (y_q == y_max);
    end else if (y_max != '0) begin
      almost_last = (x_q == '0) && (y_q == y_max - YW'(1));
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/draw_sequencer.sv
// Draw sequencer: turns a drawing control-state code into a stream of VGA
// pixel writes (brush squares or a full-screen clear), one pixel per cycle.
//
// Control handshake: an active iState is the request; it is accepted when the
// sequencer is idle and the request has not already been served. oDone pulses
// on the final pixel cycle and marks the request served until iState changes.
// Changing iState mid-operation abandons it without oDone.
module draw_sequencer
  import drawing_pkg::*;
#(
  parameter int               SCREEN_W   = SCREEN_W_DEF,
  parameter int               SCREEN_H   = SCREEN_H_DEF,
  parameter int               BRUSH      = 4,
  parameter logic [COL_W-1:0] BG_COLOUR  = BG_COLOUR_DEF,
  parameter logic [COL_W-1:0] CUR_COLOUR = CUR_COLOUR_DEF
) (
  input  logic             iClk,
  input  logic             iResetn,
  input  logic [ST_W-1:0]  iState,
  input  logic [X_W-1:0]   iX,
  input  logic [Y_W-1:0]   iY,
  input  logic [COL_W-1:0] iColour,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [COL_W-1:0] oColour,
  output logic             oPlot,
  output logic             oDone,
  output logic [1:0]       oSeqState
);

  localparam logic [X_W-1:0] SQ_X_MAX  = X_W'(BRUSH - 1);
  localparam logic [Y_W-1:0] SQ_Y_MAX  = Y_W'(BRUSH - 1);
  localparam logic [X_W-1:0] SCR_X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SCR_Y_MAX = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   W_LIM     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   H_LIM     = (Y_W+1)'(SCREEN_H);
  localparam logic           SQ_SINGLE = (BRUSH == 1);

  seq_state_e       state_q, state_d;
  logic [ST_W-1:0]  prev_state_q, prev_state_d;
  logic             served_q, served_d;
  logic [ST_W-1:0]  op_q, op_d;
  logic [X_W-1:0]   bx_q, bx_d, cur_x_q, cur_x_d, prv_x_q, prv_x_d, ox_q, ox_d;
  logic [Y_W-1:0]   by_q, by_d, cur_y_q, cur_y_d, prv_y_q, prv_y_d, oy_q, oy_d;
  logic [COL_W-1:0] col_q, col_d, oc_q, oc_d;

  logic             state_changed, start, active;
  logic [X_W-1:0]   cnt_x, lim_x;
  logic [Y_W-1:0]   cnt_y, lim_y;
  logic             cnt_last, cnt_almost_last;
  logic [X_W:0]     px;
  logic [Y_W:0]     py;

  assign state_changed = (iState != prev_state_q);
  assign start = (state_q == S_IDLE) && is_active(iState) &&
                 !(served_q && !state_changed);
  assign lim_x = (op_q == ST_CLEAR) ? SCR_X_MAX : SQ_X_MAX;
  assign lim_y = (op_q == ST_CLEAR) ? SCR_Y_MAX : SQ_Y_MAX;

  raster_counter #(.XW(X_W), .YW(Y_W)) u_raster (
    .clk         (iClk),
    .rst_n       (iResetn),
    .clr         (state_q != S_RUN),
    .en          (state_q == S_RUN),
    .x_max       (lim_x),
    .y_max       (lim_y),
    .x           (cnt_x),
    .y           (cnt_y),
    .last        (cnt_last),
    .almost_last (cnt_almost_last)
  );

  // FSM state register.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: S_DONE is the final pixel cycle; an iState change in
  // S_RUN abandons the sweep.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (SQ_SINGLE && iState != ST_CLEAR) ? S_DONE : S_RUN;
      S_RUN: begin
        if (state_changed)        state_d = S_IDLE;
        else if (cnt_almost_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pixel address is computed one bit wide so off-screen pixels
  // clip instead of wrapping; outputs hold their last values when not plotting.
  always_comb begin
    active  = (state_q == S_RUN) || (state_q == S_DONE);
    px      = {1'b0, bx_q} + {1'b0, cnt_x};
    py      = {1'b0, by_q} + {1'b0, cnt_y};
    oPlot   = active && (px < W_LIM) && (py < H_LIM);
    oDone   = (state_q == S_DONE);
    oX      = oPlot ? px[X_W-1:0] : ox_q;
    oY      = oPlot ? py[Y_W-1:0] : oy_q;
    oColour = oPlot ? col_q : oc_q;
  end

  assign oSeqState = state_q;

  // Datapath next values: request latch, served flag, cursor history.
  always_comb begin
    prev_state_d = iState;
    served_d     = served_q;
    op_d         = op_q;
    bx_d         = bx_q;
    by_d         = by_q;
    col_d        = col_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    prv_x_d      = prv_x_q;
    prv_y_d      = prv_y_q;
    ox_d         = oX;
    oy_d         = oY;
    oc_d         = oColour;

    if (state_changed)          served_d = 1'b0;
    else if (state_q == S_DONE) served_d = 1'b1;

    if (start) begin
      op_d = iState;
      case (iState)
        ST_CLEAN: begin bx_d = prv_x_q; by_d = prv_y_q; end
        ST_CLEAR: begin bx_d = '0;      by_d = '0;      end
        default:  begin bx_d = iX;      by_d = iY;      end
      endcase
      case (iState)
        ST_DRAW: col_d = iColour;
        ST_MOVE: col_d = CUR_COLOUR;
        default: col_d = BG_COLOUR;
      endcase
    end

    // A finished MOVE shifts the cursor history so CLEAN erases the square
    // the cursor has just left.
    if (state_q == S_DONE && op_q == ST_MOVE) begin
      prv_x_d = cur_x_q;
      prv_y_d = cur_y_q;
      cur_x_d = bx_q;
      cur_y_d = by_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      prev_state_q <= '0;
      served_q     <= 1'b0;
      op_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      col_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      prv_x_q      <= '0;
      prv_y_q      <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      oc_q         <= '0;
    end else begin
      prev_state_q <= prev_state_d;
      served_q     <= served_d;
      op_q         <= op_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      col_q        <= col_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      prv_x_q      <= prv_x_d;
      prv_y_q      <= prv_y_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      oc_q         <= oc_d;
    end
  end

  // The done cycle always lands on the final raster position.
  done_on_last: assert property (@(posedge iClk) disable iff (!iResetn)
    (state_q == S_DONE) |-> cnt_last);

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: a table of drawing requests with
// hand-computed results, plus sequences for abort, full clear and reset.
module tb_draw_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] i_state;
  logic [7:0] i_x;
  logic [6:0] i_y;
  logic [2:0] i_colour;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_colour;
  logic       o_plot;
  logic       o_done;
  logic [1:0] dbg_state;

  draw_sequencer dut (
    .iClk      (clk),
    .iResetn   (rst_n),
    .iState    (i_state),
    .iX        (i_x),
    .iY        (i_y),
    .iColour   (i_colour),
    .oX        (o_x),
    .oY        (o_y),
    .oColour   (o_colour),
    .oPlot     (o_plot),
    .oDone     (o_done),
    .oSeqState (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] last_seen;
  int n_checks = 0;
  int n_pass   = 0;
  int mcur_x = 0, mcur_y = 0, mprev_x = 0, mprev_y = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  typedef struct {
    logic [2:0] state;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    int         cycles;
    int         plots;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] col;
  } vec_t;

  vec_t vecs[14];

  // Driver: apply one request and score it.
  task automatic apply_row(input vec_t v);
    int bx, by, plots, done_at;
    logic [17:0] got, first_got, last_got;
    plots = 0; done_at = -1; first_got = '0; last_got = '0;
    if (v.state == i_state) begin
      @(posedge clk); #1 i_state = 3'd0;
    end
    if (v.cycles > 0) begin
      if (v.state == 3'd3) begin bx = mprev_x; by = mprev_y; end
      else begin bx = v.x; by = v.y; end
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 4; i++)
          if (bx + i < 160 && by + j < 120)
            exp_q.push_back({8'(bx + i), 7'(by + j), v.col});
    end
    @(posedge clk); #1;
    i_state = v.state; i_x = v.x; i_y = v.y; i_colour = v.colour;
    if (v.cycles > 0) begin
      for (int k = 0; k < v.cycles; k++) begin
        @(posedge clk); @(negedge clk);
        if (o_plot) begin
          got = {o_x, o_y, o_colour};
          if (plots == 0) first_got = got;
          last_got = got;
          last_seen = got;
          plots++;
          if (exp_q.size() == 0) check("unexpected_plot", 32'd1, 32'd0);
          else check("pixel", 32'(got), 32'(exp_q.pop_front()));
        end
        if (o_done && done_at < 0) done_at = k;
      end
      check("plot_count", 32'(plots), 32'(v.plots));
      check("done_cycle", 32'(done_at), 32'(v.cycles - 1));
      if (v.plots > 0) begin
        check("first_xy", 32'(first_got[17:3]), 32'({v.fx, v.fy}));
        check("last_xy", 32'(last_got[17:3]), 32'({v.lx, v.ly}));
      end
      @(posedge clk); @(negedge clk);
      check("quiet_after_done", 32'({o_plot, o_done}), 32'd0);
      if (v.state == 3'd1) begin
        mprev_x = mcur_x; mprev_y = mcur_y; mcur_x = v.x; mcur_y = v.y;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (o_plot || o_done) plots++;
      end
      check("inactive_quiet", 32'(plots), 32'd0);
    end
    check("hold_outputs", 32'({o_x, o_y, o_colour}), 32'(last_seen));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  int errs, done_at, plots;

  initial begin
    // state x y colour cycles plots first(x,y) last(x,y) colour
    vecs[0]  = '{3'd4, 8'd10,  7'd20,  3'b100, 16, 16, 8'd10,  7'd20,  8'd13,  7'd23,  3'b100};
    vecs[1]  = '{3'd4, 8'd158, 7'd118, 3'b010, 16, 4,  8'd158, 7'd118, 8'd159, 7'd119, 3'b010};
    vecs[2]  = '{3'd5, 8'd5,   7'd6,   3'b101, 16, 16, 8'd5,   7'd6,   8'd8,   7'd9,   3'b111};
    vecs[3]  = '{3'd3, 8'd99,  7'd99,  3'b001, 16, 16, 8'd0,   7'd0,   8'd3,   7'd3,   3'b111};
    vecs[4]  = '{3'd1, 8'd40,  7'd50,  3'b110, 16, 16, 8'd40,  7'd50,  8'd43,  7'd53,  3'b000};
    vecs[5]  = '{3'd2, 8'd0,   7'd0,   3'b000, 0,  0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b000};
    vecs[6]  = '{3'd3, 8'd0,   7'd0,   3'b000, 16, 16, 8'd0,   7'd0,   8'd3,   7'd3,   3'b111};
    vecs[7]  = '{3'd1, 8'd44,  7'd50,  3'b011, 16, 16, 8'd44,  7'd50,  8'd47,  7'd53,  3'b000};
    vecs[8]  = '{3'd2, 8'd0,   7'd0,   3'b000, 0,  0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b000};
    vecs[9]  = '{3'd3, 8'd0,   7'd0,   3'b000, 16, 16, 8'd40,  7'd50,  8'd43,  7'd53,  3'b111};
    vecs[10] = '{3'd4, 8'd254, 7'd100, 3'b001, 16, 0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b001};
    vecs[11] = '{3'd0, 8'd7,   7'd7,   3'b010, 0,  0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b000};
    vecs[12] = '{3'd7, 8'd7,   7'd7,   3'b010, 0,  0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b000};
    vecs[13] = '{3'd4, 8'd0,   7'd117, 3'b011, 16, 12, 8'd0,   7'd117, 8'd3,   7'd119, 3'b011};

    rst_n = 1'b0; i_state = 3'd0; i_x = '0; i_y = '0; i_colour = '0;
    last_seen = '0;
    #12;
    check("reset_x", 32'(o_x), 32'd0);
    check("reset_y", 32'(o_y), 32'd0);
    check("reset_colour", 32'(o_colour), 32'd0);
    check("reset_plot_done", 32'({o_plot, o_done}), 32'd0);
    check("reset_fsm", 32'(dbg_state), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    for (int r = 0; r < 14; r++) apply_row(vecs[r]);

    // Abort a DRAW during its 5th pixel; the next DRAW restarts at top-left.
    @(posedge clk); #1 i_state = 3'd0;
    @(posedge clk); #1 i_state = 3'd4; i_x = 8'd10; i_y = 7'd20; i_colour = 3'b011;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      if (k == 4) #1 i_state = 3'd0;
      @(negedge clk);
      check("abort_pixel", 32'({o_plot, o_x, o_y, o_colour}),
            32'({1'b1, 8'(10 + k % 4), 7'(20 + k / 4), 3'b011}));
    end
    last_seen = {8'd10, 7'd21, 3'b011};
    plots = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_plot || o_done) plots++;
    end
    check("abort_quiet", 32'(plots), 32'd0);
    apply_row('{3'd4, 8'd10, 7'd20, 3'b011, 16, 16, 8'd10, 7'd20, 8'd13, 7'd23, 3'b011});

    // Full-screen clear in raster order.
    @(posedge clk); #1 i_state = 3'd6;
    errs = 0; done_at = -1;
    for (int k = 0; k < 19200; k++) begin
      @(posedge clk); @(negedge clk);
      if (!(o_plot && o_x == 8'(k % 160) && o_y == 7'(k / 160) && o_colour == 3'b111)) errs++;
      if (o_done && done_at < 0) done_at = k;
    end
    check("clear_pixels_bad", 32'(errs), 32'd0);
    check("clear_done_cycle", 32'(done_at), 32'd19199);
    check("clear_last_xy", 32'({o_x, o_y}), 32'({8'd159, 7'd119}));
    plots = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_plot || o_done) plots++;
    end
    check("clear_no_repeat", 32'(plots), 32'd0);

    // Reset in the middle of a clear, then restart from (0,0).
    @(posedge clk); #1 i_state = 3'd0;
    @(posedge clk); #1 i_state = 3'd6;
    errs = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); @(negedge clk);
      if (!(o_plot && !o_done && o_x == 8'(k) && o_y == 7'd0)) errs++;
    end
    check("preclear_pixels_bad", 32'(errs), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({o_x, o_y, o_colour, o_plot, o_done}), 32'd0);
    check("midreset_fsm", 32'(dbg_state), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check("restart_pixel", 32'({o_plot, o_done, o_x, o_y, o_colour}),
            32'({1'b1, 1'b0, 8'(k), 7'd0, 3'b111}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
